// File: rtl/chacha_pkg.sv
// Purpose: shared encodings and sequencing tables for the ChaCha round controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package chacha_pkg;

  // Controller states; one block walks CLEAR -> (COL DSHIFT DIAG USHIFT)* -> ADD -> DONE -> INC
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CLEAR  = 4'd1,
    ST_COL    = 4'd2,
    ST_DSHIFT = 4'd3,
    ST_DIAG   = 4'd4,
    ST_USHIFT = 4'd5,
    ST_ADD    = 4'd6,
    ST_DONE   = 4'd7,
    ST_INC    = 4'd8
  } state_t;

  // Four quarter-round steps per column/diagonal pass
  localparam logic [2:0] QR_LEN    = 3'd4;
  // Six single-column rotations realign b/c/d rows (1+2+3)
  localparam logic [2:0] SHIFT_LEN = 3'd6;

  // Diagonalising rotation: b once, c twice, d three times
  function automatic logic [1:0] dshift_step(input logic [2:0] idx);
    logic [1:0] r;
    case (idx)
      3'd0:       r = 2'd1;
      3'd1, 3'd2: r = 2'd2;
      default:    r = 2'd3;
    endcase
    return r;
  endfunction

  // Un-diagonalising rotation: b three more times, c twice, d once (net identity)
  function automatic logic [1:0] ushift_step(input logic [2:0] idx);
    logic [1:0] r;
    case (idx)
      3'd0, 3'd1, 3'd2: r = 2'd1;
      3'd3, 3'd4:       r = 2'd2;
      default:          r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chacha_round_ctrl.sv
// Purpose: sequences one ChaCha keystream block (clear, double rounds, add-back, counter bump).
// Latency: start at edge 0 -> clear in cycle 1, add_back in 20*DOUBLE_ROUNDS+2, done from 20*DOUBLE_ROUNDS+3.
// Backpressure: holds done until ack; start outside IDLE and ack outside DONE are dropped.
module chacha_round_ctrl #(
  parameter int DOUBLE_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
  output logic       busy,
  output logic       done,
  output logic       clear,
  output logic       calc,
  output logic       shift,
  output logic [1:0] step,
  output logic       add_back,
  output logic       inc_ctr
);
  import chacha_pkg::*;

  state_t     state, nxt_state;
  logic [2:0] sub, nxt_sub;
  logic [3:0] dr_cnt, nxt_dr;

  logic       busy_d, done_d, clear_d, calc_d, shift_d, add_d, inc_d;
  logic [1:0] step_d;

  // Next-state logic; sub-step counter restarts at 0 on every state change
  always_comb begin
    nxt_state = state;
    nxt_sub   = 3'd0;
    nxt_dr    = dr_cnt;
    case (state)
      ST_IDLE:   if (start) nxt_state = ST_CLEAR;
      ST_CLEAR: begin
        nxt_state = ST_COL;
        nxt_dr    = 4'd0;
      end
      ST_COL: begin
        if (sub == QR_LEN - 3'd1) nxt_state = ST_DSHIFT;
        else                      nxt_sub   = sub + 3'd1;
      end
      ST_DSHIFT: begin
        if (sub == SHIFT_LEN - 3'd1) nxt_state = ST_DIAG;
        else                         nxt_sub   = sub + 3'd1;
      end
      ST_DIAG: begin
        if (sub == QR_LEN - 3'd1) nxt_state = ST_USHIFT;
        else                      nxt_sub   = sub + 3'd1;
      end
      ST_USHIFT: begin
        if (sub == SHIFT_LEN - 3'd1) begin
          // A double round completes here; decide whether another is due
          nxt_dr    = dr_cnt + 4'd1;
          nxt_state = (nxt_dr == 4'(DOUBLE_ROUNDS)) ? ST_ADD : ST_COL;
        end else begin
          nxt_sub = sub + 3'd1;
        end
      end
      ST_ADD:    nxt_state = ST_DONE;
      ST_DONE:   if (ack) nxt_state = ST_INC;
      ST_INC:    nxt_state = ST_IDLE;
      default:   nxt_state = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    busy_d  = (nxt_state != ST_IDLE);
    done_d  = 1'b0;
    clear_d = 1'b0;
    calc_d  = 1'b0;
    shift_d = 1'b0;
    add_d   = 1'b0;
    inc_d   = 1'b0;
    step_d  = 2'd0;
    case (nxt_state)
      ST_CLEAR:  clear_d = 1'b1;
      ST_COL, ST_DIAG: begin
        calc_d = 1'b1;
        step_d = nxt_sub[1:0];
      end
      ST_DSHIFT: begin
        shift_d = 1'b1;
        step_d  = dshift_step(nxt_sub);
      end
      ST_USHIFT: begin
        shift_d = 1'b1;
        step_d  = ushift_step(nxt_sub);
      end
      ST_ADD:    add_d  = 1'b1;
      ST_DONE:   done_d = 1'b1;
      ST_INC:    inc_d  = 1'b1;
      default:   ;
    endcase
  end

  // State, counters and registered outputs; reset wins over start/ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sub      <= 3'd0;
      dr_cnt   <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      clear    <= 1'b0;
      calc     <= 1'b0;
      shift    <= 1'b0;
      step     <= 2'd0;
      add_back <= 1'b0;
      inc_ctr  <= 1'b0;
    end else begin
      state    <= nxt_state;
      sub      <= nxt_sub;
      dr_cnt   <= nxt_dr;
      busy     <= busy_d;
      done     <= done_d;
      clear    <= clear_d;
      calc     <= calc_d;
      shift    <= shift_d;
      step     <= step_d;
      add_back <= add_d;
      inc_ctr  <= inc_d;
    end
  end

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// Purpose: self-checking bench for chacha_round_ctrl (DOUBLE_ROUNDS=10 and =1 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_chacha_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i   [2];
  logic       start_i [2];
  logic       ack_i   [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       clear_o [2];
  logic       calc_o  [2];
  logic       shift_o [2];
  logic [1:0] step_o  [2];
  logic       add_o   [2];
  logic       inc_o   [2];

  chacha_round_ctrl u_dut10 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .ack(ack_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .clear(clear_o[0]), .calc(calc_o[0]),
    .shift(shift_o[0]), .step(step_o[0]), .add_back(add_o[0]), .inc_ctr(inc_o[0])
  );

  chacha_round_ctrl #(.DOUBLE_ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .ack(ack_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .clear(clear_o[1]), .calc(calc_o[1]),
    .shift(shift_o[1]), .step(step_o[1]), .add_back(add_o[1]), .inc_ctr(inc_o[1])
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_clear, cnt_calc_col, cnt_calc_diag, cnt_dshift, cnt_ushift;

  // Rotation tables straight from the row-rotation amounts (b,c,d = 1,2,3 then 3,2,1)
  int dtab [6] = '{1, 2, 2, 3, 3, 3};
  int utab [6] = '{1, 1, 1, 2, 2, 3};

  // Vector layout: {busy, done, clear, calc, shift, step[1:0], add_back, inc_ctr}
  function automatic logic [8:0] mk(input bit b, input bit d, input bit c, input bit ca,
                                    input bit s, input int st, input bit a, input bit i);
    logic [1:0] st2;
    st2 = 2'(st);
    return {b, d, c, ca, s, st2, a, i};
  endfunction

  function automatic logic [8:0] obs(input int u);
    return {busy_o[u], done_o[u], clear_o[u], calc_o[u], shift_o[u], step_o[u], add_o[u], inc_o[u]};
  endfunction

  localparam logic [8:0] V_IDLE = 9'd0;

  // Expected outputs k cycles after the start edge: each double round is a 20-cycle frame
  function automatic logic [8:0] model(input int k, input int dr);
    int t;
    if (k == 1) return mk(1, 0, 1, 0, 0, 0, 0, 0);
    if (k <= 20 * dr + 1) begin
      t = (k - 2) % 20;
      if (t < 4)  return mk(1, 0, 0, 1, 0, t, 0, 0);
      if (t < 10) return mk(1, 0, 0, 0, 1, dtab[t - 4], 0, 0);
      if (t < 14) return mk(1, 0, 0, 1, 0, t - 10, 0, 0);
      return mk(1, 0, 0, 0, 1, utab[t - 14], 0, 0);
    end
    if (k == 20 * dr + 2) return mk(1, 0, 0, 0, 0, 0, 1, 0);
    return mk(1, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Full block from IDLE: noise 0 = clean, 1 = random start/ack, 2 = start at 100 and ack at 50
  task automatic run_block(input int u, input int dr, input int ack_delay, input int noise);
    logic [8:0] v;
    cnt_clear = 0; cnt_calc_col = 0; cnt_calc_diag = 0; cnt_dshift = 0; cnt_ushift = 0;
    start_i[u] = 1'b1;
    tick();
    start_i[u] = 1'b0;
    for (int k = 1; k <= 20 * dr + 2; k++) begin
      v = obs(u);
      chk("trace", v, model(k, dr));
      if (clear_o[u]) cnt_clear++;
      if (calc_o[u] && ((k - 2) % 20) < 4)  cnt_calc_col++;
      if (calc_o[u] && ((k - 2) % 20) >= 10) cnt_calc_diag++;
      if (shift_o[u] && ((k - 2) % 20) < 10) cnt_dshift++;
      if (shift_o[u] && ((k - 2) % 20) >= 14) cnt_ushift++;
      if (noise == 1) begin
        start_i[u] = 1'($urandom_range(0, 1));
        ack_i[u]   = 1'($urandom_range(0, 1));
      end else if (noise == 2) begin
        start_i[u] = (k == 100);
        ack_i[u]   = (k == 50);
      end
      tick();
    end
    start_i[u] = 1'b0;
    ack_i[u]   = 1'b0;
    for (int d = 0; d <= ack_delay; d++) begin
      chk("done_hold", obs(u), mk(1, 1, 0, 0, 0, 0, 0, 0));
      if (d == ack_delay) ack_i[u] = 1'b1;
      tick();
    end
    ack_i[u] = 1'b0;
    chk("inc", obs(u), mk(1, 0, 0, 0, 0, 0, 0, 1));
    tick();
    chk("idle_after_inc", obs(u), V_IDLE);
  endtask

  typedef struct {
    int         k;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl [$];

  task automatic addv(input int k, input logic [8:0] e);
    vec_t r;
    r.k = k;
    r.exp = e;
    tbl.push_back(r);
  endtask

  initial begin
    int cur;
    int kr;
    for (int u = 0; u < 2; u++) begin
      rst_i[u] = 1'b1; start_i[u] = 1'b0; ack_i[u] = 1'b0;
    end

    // Checkpoints of a default block, offsets counted from the start edge
    addv(1,   mk(1, 0, 1, 0, 0, 0, 0, 0));
    addv(2,   mk(1, 0, 0, 1, 0, 0, 0, 0));
    addv(3,   mk(1, 0, 0, 1, 0, 1, 0, 0));
    addv(5,   mk(1, 0, 0, 1, 0, 3, 0, 0));
    addv(6,   mk(1, 0, 0, 0, 1, 1, 0, 0));
    addv(7,   mk(1, 0, 0, 0, 1, 2, 0, 0));
    addv(9,   mk(1, 0, 0, 0, 1, 3, 0, 0));
    addv(12,  mk(1, 0, 0, 1, 0, 0, 0, 0));
    addv(15,  mk(1, 0, 0, 1, 0, 3, 0, 0));
    addv(16,  mk(1, 0, 0, 0, 1, 1, 0, 0));
    addv(19,  mk(1, 0, 0, 0, 1, 2, 0, 0));
    addv(21,  mk(1, 0, 0, 0, 1, 3, 0, 0));
    addv(22,  mk(1, 0, 0, 1, 0, 0, 0, 0));
    addv(201, mk(1, 0, 0, 0, 1, 3, 0, 0));
    addv(202, mk(1, 0, 0, 0, 0, 0, 1, 0));
    addv(203, mk(1, 1, 0, 0, 0, 0, 0, 0));

    tick(); tick();
    chk("reset_state_dr10", obs(0), V_IDLE);
    chk("reset_state_dr1", obs(1), V_IDLE);
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    tick();
    chk("idle_no_start", obs(0), V_IDLE);

    // Table-driven checkpoints, then ack withheld for 50 cycles
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    cur = 1;
    foreach (tbl[i]) begin
      while (cur < tbl[i].k) begin
        tick();
        cur++;
      end
      chk($sformatf("vec_k%0d", tbl[i].k), obs(0), tbl[i].exp);
    end
    for (int d = 0; d < 50; d++) begin
      tick();
      chk("done_withheld", obs(0), mk(1, 1, 0, 0, 0, 0, 0, 0));
    end
    ack_i[0] = 1'b1;
    tick();
    ack_i[0] = 1'b0;
    chk("inc_pulse", obs(0), mk(1, 0, 0, 0, 0, 0, 0, 1));
    tick();
    chk("busy_drop", obs(0), V_IDLE);
    tick();
    chk("idle_stays", obs(0), V_IDLE);

    // Clean block with operation tallies
    run_block(0, 10, 0, 0);
    chk_int("n_clear", cnt_clear, 1);
    chk_int("n_col_calc", cnt_calc_col, 40);
    chk_int("n_dshift", cnt_dshift, 60);
    chk_int("n_diag_calc", cnt_calc_diag, 40);
    chk_int("n_ushift", cnt_ushift, 60);

    // Stray start at cycle 100 and early ack at cycle 50
    run_block(0, 10, 3, 2);

    // Reset in cycle 57 of a block
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    for (int k = 1; k <= 57; k++) begin
      chk("pre_reset_trace", obs(0), model(k, 10));
      if (k < 57) tick();
    end
    rst_i[0] = 1'b1;
    start_i[0] = 1'b1;
    ack_i[0] = 1'b1;
    tick();
    rst_i[0] = 1'b0;
    start_i[0] = 1'b0;
    ack_i[0] = 1'b0;
    chk("mid_reset_zero", obs(0), V_IDLE);
    tick();
    chk("post_reset_idle", obs(0), V_IDLE);
    run_block(0, 10, 1, 0);

    // Back-to-back blocks with one double round
    run_block(1, 1, 0, 0);
    run_block(1, 1, 0, 0);

    // Randomized blocks with random ack delay and spurious inputs
    for (int i = 0; i < 20; i++) run_block(1, 1, int'($urandom_range(0, 5)), 1);
    for (int i = 0; i < 2; i++)  run_block(0, 10, int'($urandom_range(0, 3)), 1);

    // Randomized reset points within a short block
    for (int i = 0; i < 8; i++) begin
      kr = int'($urandom_range(1, 23));
      start_i[1] = 1'b1;
      tick();
      start_i[1] = 1'b0;
      for (int k = 1; k <= kr; k++) begin
        chk("rand_reset_trace", obs(1), model(k, 1));
        if (k < kr) tick();
      end
      rst_i[1] = 1'b1;
      ack_i[1] = 1'($urandom_range(0, 1));
      tick();
      rst_i[1] = 1'b0;
      ack_i[1] = 1'b0;
      chk("rand_reset_zero", obs(1), V_IDLE);
      tick();
      chk("rand_reset_idle", obs(1), V_IDLE);
    end
    run_block(1, 1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
